oled_cmd_sequencer: RTL and testbench

//  Host-side controller for the 1-bit framebuffer. Oversamples the host's SSD1306-style

---
 rtl/oled_cmd_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oled_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// oled_cmd_sequencer
//   Host-side controller for the 1-bit framebuffer. Oversamples an SSD1306-style
//   serial bus (sclk/mosi/dc/cs) in the CLK25MHz domain and assembles bytes.
//   Command bytes update the page/column pointers and the display state. Data
//   bytes become one-cycle framebuffer write strobes.
//
//   Optional feature macro: HORIZ_ADDR_MODE_EN
//     Defined   : command 0x20 takes a mode argument. Horizontal mode carries a
//                 column wrap into the page, and a page wrap 7->0 pulses
//                 page0_sync.
//     Undefined : page addressing only. 0x20 is ignored like any unknown code.
//
// Ports
//   CLK25MHz   in   system clock
//   reset      in   asynchronous active-high reset
//   sclk/mosi  in   host serial clock and data (async; MSB first, rising edge)
//   dc         in   1=data byte, 0=command byte (sampled with the last bit)
//   cs         in   active-low chip select
//   fb_we      out  one-cycle framebuffer write strobe
//   fb_addr    out  {page,col} of the write
//   fb_wdata   out  data byte written
//   display_on out  0xAE/0xAF state
//   invert     out  0xA6/0xA7 state
//   contrast   out  argument of 0x81
//   page0_sync out  one-cycle pulse when the page becomes 0
// -----------------------------------------------------------------------------
module oled_cmd_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int COL_W       = 7,
   parameter int PAGE_W      = 3
) (
   input  logic                    CLK25MHz,
   input  logic                    reset,
   input  logic                    sclk,
   input  logic                    mosi,
   input  logic                    dc,
   input  logic                    cs,
   output logic                    fb_we,
   output logic [PAGE_W+COL_W-1:0] fb_addr,
   output logic [7:0]              fb_wdata,
   output logic                    display_on,
   output logic                    invert,
   output logic [7:0]              contrast,
   output logic                    page0_sync
);

   typedef enum logic [1:0] {ST_CMD, ST_ARG_CONTRAST, ST_ARG_MODE} state_t;

   // Synchronisers for {cs,dc,mosi,sclk}. cs resets to 1 so no edge is seen
   // during reset.
   logic [3:0] sync_q [SYNC_STAGES];
   logic       sclk_prev_q;
   logic       s_sclk, s_mosi, s_dc, s_cs, rise;

   assign {s_cs, s_dc, s_mosi, s_sclk} = sync_q[SYNC_STAGES-1];
   assign rise = s_sclk & ~sclk_prev_q & ~s_cs;

   always_ff @(posedge CLK25MHz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1000;
         sclk_prev_q <= 1'b0;
      end else begin
         sync_q[0] <= {cs, dc, mosi, sclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sclk_prev_q <= s_sclk;
      end
   end

   // Byte assembly. done_q is a one-cycle pulse carrying the completed byte.
   logic [6:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       done_q;
   logic [7:0] byte_q;
   logic       byte_dc_q;

   always_ff @(posedge CLK25MHz or posedge reset) begin
      if (reset) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         byte_q    <= '0;
         byte_dc_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (s_cs) begin
            bit_cnt_q <= '0;
         end else if (rise) begin
            shift_q   <= {shift_q[5:0], s_mosi};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               done_q    <= 1'b1;
               byte_q    <= {shift_q, s_mosi};
               byte_dc_q <= s_dc;
            end
         end
      end
   end

   // Command / data decoder
   state_t                    state_q, state_d;
   logic [PAGE_W-1:0]         page_q, page_d;
   logic [COL_W-1:0]          col_q, col_d;
   logic                      disp_q, disp_d, inv_q, inv_d;
   logic [7:0]                contrast_q, contrast_d;
   logic                      we_q, we_d, p0_q, p0_d;
   logic [PAGE_W+COL_W-1:0]   addr_q, addr_d;
   logic [7:0]                wdata_q, wdata_d;
`ifdef HORIZ_ADDR_MODE_EN
   logic                      horiz_q, horiz_d;
`endif

   always_ff @(posedge CLK25MHz or posedge reset) begin
      if (reset) begin
         state_q    <= ST_CMD;
         page_q     <= '0;
         col_q      <= '0;
         disp_q     <= 1'b0;
         inv_q      <= 1'b0;
         contrast_q <= 8'h7F;
         we_q       <= 1'b0;
         p0_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef HORIZ_ADDR_MODE_EN
         horiz_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         col_q      <= col_d;
         disp_q     <= disp_d;
         inv_q      <= inv_d;
         contrast_q <= contrast_d;
         we_q       <= we_d;
         p0_q       <= p0_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
`ifdef HORIZ_ADDR_MODE_EN
         horiz_q    <= horiz_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      col_d      = col_q;
      disp_d     = disp_q;
      inv_d      = inv_q;
      contrast_d = contrast_q;
      we_d       = 1'b0;
      p0_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
`ifdef HORIZ_ADDR_MODE_EN
      horiz_d    = horiz_q;
`endif
      if (done_q) begin
         case (state_q)
            ST_CMD: begin
               if (byte_dc_q) begin
                  we_d    = 1'b1;
                  addr_d  = {page_q, col_q};
                  wdata_d = byte_q;
                  col_d   = col_q + 1'b1;
`ifdef HORIZ_ADDR_MODE_EN
                  // Horizontal mode carries the column wrap into the page.
                  if (horiz_q && (col_q == '1)) begin
                     page_d = page_q + 1'b1;
                     if (page_q == '1) p0_d = 1'b1;
                  end
`endif
               end else if (byte_q[7:4] == 4'h0) begin
                  col_d[3:0] = byte_q[3:0];
               end else if (byte_q[7:3] == 5'b00010) begin
                  col_d[COL_W-1:4] = byte_q[COL_W-5:0];
               end else if (byte_q[7:3] == 5'b10110) begin
                  page_d = byte_q[PAGE_W-1:0];
                  if (byte_q[PAGE_W-1:0] == '0) p0_d = 1'b1;
               end else begin
                  case (byte_q)
                     8'hAE: disp_d = 1'b0;
                     8'hAF: disp_d = 1'b1;
                     8'hA6: inv_d = 1'b0;
                     8'hA7: inv_d = 1'b1;
                     8'h81: state_d = ST_ARG_CONTRAST;
`ifdef HORIZ_ADDR_MODE_EN
                     8'h20: state_d = ST_ARG_MODE;
`endif
                     default: ;
                  endcase
               end
            end
            ST_ARG_CONTRAST: begin
               // Argument byte: dc is irrelevant here.
               contrast_d = byte_q;
               state_d    = ST_CMD;
            end
`ifdef HORIZ_ADDR_MODE_EN
            ST_ARG_MODE: begin
               horiz_d = (byte_q[1:0] == 2'b00);
               state_d = ST_CMD;
            end
`endif
            default: state_d = ST_CMD;
         endcase
      end
      // Deselect aborts any pending argument; a completed byte is still handled.
      if (s_cs) state_d = ST_CMD;
   end

   assign fb_we      = we_q;
   assign fb_addr    = addr_q;
   assign fb_wdata   = wdata_q;
   assign display_on = disp_q;
   assign invert     = inv_q;
   assign contrast   = contrast_q;
   assign page0_sync = p0_q;

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
module tb_oled_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset, sclk, mosi, dc, cs;
   logic       fb_we;
   logic [9:0] fb_addr;
   logic [7:0] fb_wdata;
   logic       display_on, invert, page0_sync;
   logic [7:0] contrast;

   always #20 clk = ~clk;

   oled_cmd_sequencer dut (
      .CLK25MHz(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .dc(dc), .cs(cs),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
      .display_on(display_on), .invert(invert), .contrast(contrast),
      .page0_sync(page0_sync)
   );

   typedef struct packed {
      logic       dc;
      logic [7:0] b;
      logic       we;
      logic [9:0] addr;
      logic       p0;
   } vec_t;

   vec_t        tbl[$];
   logic [17:0] exp_q[$];   // {addr, data} of expected writes
   int          errors = 0;
   int          checks = 0;
   int          p0_cnt = 0;
   int          exp_p0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; samples outputs on the falling edge and pops the scoreboard.
   task automatic tick();
      logic [17:0] e;
      @(negedge clk);
      if (fb_we === 1'b1) begin
         $display("write addr=%0d data=%02h", fb_addr, fb_wdata);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h expected none", fb_addr, fb_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {22'd0, fb_addr}, {22'd0, e[17:8]});
            chk("wr_data", {24'd0, fb_wdata}, {24'd0, e[7:0]});
         end
      end
      if (page0_sync === 1'b1) p0_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Sends the first nbits of b (MSB first), sclk period = 8 system clocks.
   task automatic send(input logic d, input logic [7:0] b, input int nbits, input int gap);
      logic [7:0] v;
      v = b;
      dc = d;
      for (int i = 0; i < nbits; i++) begin
         mosi = v[7-i];
         ticks(4);
         sclk = 1'b1;
         ticks(4);
         sclk = 1'b0;
      end
      ticks(gap);
   endtask

   task automatic expect_wr(input logic [9:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic add(input logic d, input logic [7:0] b, input logic we,
                      input logic [9:0] a, input logic p0);
      tbl.push_back({d, b, we, a, p0});
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_fb_we"}, {31'd0, fb_we}, 32'd0);
      chk({tag, "_fb_addr"}, {22'd0, fb_addr}, 32'd0);
      chk({tag, "_fb_wdata"}, {24'd0, fb_wdata}, 32'd0);
      chk({tag, "_display_on"}, {31'd0, display_on}, 32'd0);
      chk({tag, "_invert"}, {31'd0, invert}, 32'd0);
      chk({tag, "_contrast"}, {24'd0, contrast}, 32'h7F);
      chk({tag, "_page0_sync"}, {31'd0, page0_sync}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0; cs = 1'b1;
      ticks(3);
      check_reset_vals("reset");
      reset = 1'b0;
      ticks(4);
      cs = 1'b0;
      ticks(4);

      // set page/col then write; contrast argument; page0 marker; column wrap
      add(0, 8'hB3, 0, 10'd0, 0);
      add(0, 8'h05, 0, 10'd0, 0);
      add(0, 8'h12, 0, 10'd0, 0);
      add(1, 8'hA5, 1, {3'd3, 7'd37}, 0);
      add(0, 8'h81, 0, 10'd0, 0);
      add(0, 8'h3C, 0, 10'd0, 0);
      add(0, 8'hAF, 0, 10'd0, 0);
      add(0, 8'hA7, 0, 10'd0, 0);
      add(0, 8'hB5, 0, 10'd0, 0);
      add(0, 8'hB0, 0, 10'd0, 1);
      add(0, 8'h0F, 0, 10'd0, 0);
      add(0, 8'h17, 0, 10'd0, 0);
      add(1, 8'h11, 1, {3'd0, 7'd127}, 0);
      add(1, 8'h22, 1, {3'd0, 7'd0}, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         $display("tx dc=%0d byte=%02h", tbl[i].dc, tbl[i].b);
         if (tbl[i].we) expect_wr(tbl[i].addr, tbl[i].b);
         if (tbl[i].p0) exp_p0++;
         send(tbl[i].dc, tbl[i].b, 8, 8);
         chk("pending_writes", exp_q.size(), 32'd0);
         chk("page0_sync_count", p0_cnt, exp_p0);
      end
      chk("contrast", {24'd0, contrast}, 32'h3C);
      chk("display_on", {31'd0, display_on}, 32'd1);
      chk("invert", {31'd0, invert}, 32'd1);

      // back-to-back data bytes, no idle gap between them
      $display("tx back-to-back data 44 55");
      expect_wr({3'd0, 7'd1}, 8'h44);
      expect_wr({3'd0, 7'd2}, 8'h55);
      send(1, 8'h44, 8, 0);
      send(1, 8'h55, 8, 12);
      chk("b2b_pending", exp_q.size(), 32'd0);

      // cs dropped after 5 bits: partial byte discarded
      $display("tx partial 5 bits, cs toggle, data FF");
      send(1, 8'h00, 5, 2);
      cs = 1'b1;
      ticks(8);
      cs = 1'b0;
      ticks(4);
      expect_wr({3'd0, 7'd3}, 8'hFF);
      send(1, 8'hFF, 8, 8);
      chk("partial_pending", exp_q.size(), 32'd0);

      // reset in the middle of a byte
      $display("tx reset mid-byte");
      send(1, 8'hC3, 3, 1);
      reset = 1'b1;
      #2;
      check_reset_vals("midreset");
      ticks(3);
      reset = 1'b0;
      ticks(4);
      expect_wr(10'd0, 8'h5A);
      send(1, 8'h5A, 8, 8);
      chk("after_reset_pending", exp_q.size(), 32'd0);

`ifdef HORIZ_ADDR_MODE_EN
      $display("tx horizontal mode wrap");
      send(0, 8'h20, 8, 8);
      send(0, 8'h00, 8, 8);
      send(0, 8'hB7, 8, 8);
      send(0, 8'h0F, 8, 8);
      send(0, 8'h17, 8, 8);
      expect_wr({3'd7, 7'd127}, 8'h01);
      expect_wr({3'd0, 7'd0}, 8'h02);
      exp_p0++;
      send(1, 8'h01, 8, 8);
      send(1, 8'h02, 8, 8);
      chk("horiz_pending", exp_q.size(), 32'd0);
      chk("horiz_page0_sync", p0_cnt, exp_p0);
`else
      // 0x20 ignored; its would-be argument 0xB2 is decoded as a command
      $display("tx 0x20 ignored, B2 as command");
      send(0, 8'h20, 8, 8);
      send(0, 8'hB2, 8, 8);
      expect_wr({3'd2, 7'd1}, 8'h77);
      send(1, 8'h77, 8, 8);
      chk("cmd20_pending", exp_q.size(), 32'd0);
      chk("cmd20_page0_sync", p0_cnt, exp_p0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
